// File: rtl/spongent_core.sv
// SPONGENT-pi[b] sponge engine: absorbs a RATE-bit block into the low state bits,
// then applies the full permutation at one round per clock.
module spongent_core #(
   parameter int RATE         = 18,
   parameter int MIN_CAPACITY = 128
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_continue,
   input  logic            msg_data_available,
   input  logic [RATE-1:0] data_in,
   output logic            busy,
   output logic [RATE-1:0] data_out
);

   function automatic int pick_b(input int need);
      if (need <= 88)       return 88;
      else if (need <= 136) return 136;
      else if (need <= 176) return 176;
      else if (need <= 240) return 240;
      else if (need <= 272) return 272;
      else                  return 0;
   endfunction

   function automatic int rounds_of(input int b);
      case (b)
         88:      return 45;
         136:     return 70;
         176:     return 90;
         240:     return 120;
         272:     return 140;
         default: return 1;
      endcase
   endfunction

   function automatic int lfsr_init_of(input int b);
      case (b)
         88:      return 'h05;
         136:     return 'h7A;
         176:     return 'h45;
         240:     return 'h01;
         272:     return 'h9E;
         default: return 'h01;
      endcase
   endfunction

   localparam int B     = pick_b(RATE + MIN_CAPACITY);
   localparam int R     = rounds_of(B);
   localparam int L     = (B == 88) ? 6 : ((B == 272) ? 8 : 7);
   // Feedback taps of the Fibonacci LFSR as a mask over the register bits.
   localparam int TAPS  = (L == 6) ? 'h30 : ((L == 8) ? 'h8E : 'h60);
   localparam logic [L-1:0] LFSR_INIT = L'(lfsr_init_of(B));
   localparam logic [L-1:0] LFSR_TAPS = L'(TAPS);
   localparam logic [7:0]   LAST_ROUND = 8'(R - 1);

   generate
      if (B == 0) begin : g_bad_cfg
         $error("spongent_core: RATE+MIN_CAPACITY exceeds the largest state width 272");
      end
   endgenerate

   typedef enum logic {IDLE, PERMUTE} fsm_t;

   fsm_t         fsm;
   logic [B-1:0] state;
   logic [L-1:0] lfsr;
   logic [7:0]   round;

   logic [B-1:0] ctr_state;
   logic [B-1:0] sbox_state;
   logic [B-1:0] perm_state;
   logic [L-1:0] lfsr_next;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hE;  4'h1: return 4'hD;  4'h2: return 4'hB;  4'h3: return 4'h0;
         4'h4: return 4'h2;  4'h5: return 4'h1;  4'h6: return 4'h4;  4'h7: return 4'hF;
         4'h8: return 4'h7;  4'h9: return 4'hA;  4'hA: return 4'h8;  4'hB: return 4'h5;
         4'hC: return 4'h9;  4'hD: return 4'hC;  4'hE: return 4'h3;  default: return 4'h6;
      endcase
   endfunction

   // Counter add at both ends of the state, then the nibble S-box layer.
   always_comb begin
      ctr_state = state;
      for (int k = 0; k < L; k++) begin
         ctr_state[k]     = ctr_state[k] ^ lfsr[k];
         ctr_state[B-1-k] = ctr_state[B-1-k] ^ lfsr[k];
      end
      sbox_state = '0;
      for (int n = 0; n < B/4; n++) begin
         sbox_state[4*n +: 4] = sbox(ctr_state[4*n +: 4]);
      end
      lfsr_next = {lfsr[L-2:0], ^(lfsr & LFSR_TAPS)};
   end

   genvar j;
   generate
      for (j = 0; j < B-1; j++) begin : g_player
         assign perm_state[(j*B/4) % (B-1)] = sbox_state[j];
      end
   endgenerate
   assign perm_state[B-1] = sbox_state[B-1];

   assign data_out = state[RATE-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm   <= IDLE;
         state <= '0;
         lfsr  <= '0;
         round <= '0;
         busy  <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (start_continue) begin
                  if (msg_data_available) begin
                     state[RATE-1:0] <= state[RATE-1:0] ^ data_in;
                  end
                  round <= '0;
                  lfsr  <= LFSR_INIT;
                  fsm   <= PERMUTE;
                  busy  <= 1'b1;
               end
            end
            PERMUTE: begin
               state <= perm_state;
               lfsr  <= lfsr_next;
               round <= round + 8'd1;
               if (round == LAST_ROUND) begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spongent_core.sv
// Bench for spongent_core: b=176 default instance and a b=88 instance, compared
// against a bit-level SPONGENT sponge model.
module tb_spongent_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, msg = 1'b0;
   logic [17:0] din = '0;
   logic        busy;
   logic [17:0] dout;
   logic        start2 = 1'b0, msg2 = 1'b0;
   logic [7:0]  din2 = '0;
   logic        busy2;
   logic [7:0]  dout2;

   int checks = 0;
   int failures = 0;
   int sbox_tab[16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};

   always #5 clk = ~clk;

   spongent_core dut (
      .clk(clk), .reset(reset), .start_continue(start), .msg_data_available(msg),
      .data_in(din), .busy(busy), .data_out(dout)
   );

   spongent_core #(.RATE(8), .MIN_CAPACITY(80)) dut88 (
      .clk(clk), .reset(reset), .start_continue(start2), .msg_data_available(msg2),
      .data_in(din2), .busy(busy2), .data_out(dout2)
   );

   // Reference permutation straight from the round description.
   function automatic logic [271:0] model_perm(input logic [271:0] s_in, input int b);
      logic [271:0] s, t;
      int r, l, lfsr, fb, nib;
      s = s_in;
      case (b)
         88:      begin r = 45;  l = 6; lfsr = 'h05; end
         136:     begin r = 70;  l = 7; lfsr = 'h7A; end
         176:     begin r = 90;  l = 7; lfsr = 'h45; end
         240:     begin r = 120; l = 7; lfsr = 'h01; end
         default: begin r = 140; l = 8; lfsr = 'h9E; end
      endcase
      for (int i = 0; i < r; i++) begin
         for (int k = 0; k < l; k++) begin
            s[k]     = s[k] ^ lfsr[k];
            s[b-1-k] = s[b-1-k] ^ lfsr[k];
         end
         for (int n = 0; n < b/4; n++) begin
            nib = int'(s[4*n +: 4]);
            s[4*n +: 4] = 4'(sbox_tab[nib]);
         end
         t = '0;
         for (int q = 0; q < b-1; q++) t[(q*b/4) % (b-1)] = s[q];
         t[b-1] = s[b-1];
         s = t;
         if (l == 6)      fb = ((lfsr >> 5) ^ (lfsr >> 4)) & 1;
         else if (l == 7) fb = ((lfsr >> 6) ^ (lfsr >> 5)) & 1;
         else             fb = ((lfsr >> 7) ^ (lfsr >> 3) ^ (lfsr >> 2) ^ (lfsr >> 1)) & 1;
         lfsr = ((lfsr << 1) | fb) & ((1 << l) - 1);
      end
      return s;
   endfunction

   function automatic logic [271:0] model_duplex(input logic [271:0] s_in, input logic mav,
                                                 input logic [17:0] d, input int rate, input int b);
      logic [271:0] s;
      s = s_in;
      if (mav) for (int k = 0; k < rate; k++) s[k] = s[k] ^ d[k];
      return model_perm(s, b);
   endfunction

   task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; start2 = 1'b0; msg = 1'b0; msg2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Starts and ends at a negedge; the final negedge is the first idle cycle.
   task automatic run_call(input int sel, input logic mav, input logic [17:0] d,
                           input int pa, input int pb, output int nb);
      if (sel == 0) begin start = 1'b1; msg = mav; din = d; end
      else begin start2 = 1'b1; msg2 = mav; din2 = d[7:0]; end
      @(negedge clk);
      start = 1'b0; start2 = 1'b0; msg = 1'b0; msg2 = 1'b0;
      nb = 0;
      while (((sel == 0) ? busy : busy2) && nb < 1000) begin
         nb++;
         if (sel == 0) begin
            start = (nb == pa) || (nb == pb);
            msg   = start;
            din   = 18'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0; msg = 1'b0;
   endtask

   typedef struct {
      logic        do_reset;
      logic        mav;
      logic [17:0] din;
      logic [17:0] exp;
   } vec_t;

   vec_t         vecs[8];
   logic [271:0] ms;
   logic [17:0]  single_exp;
   int           nb;
   time          t1, t2;

   initial begin
      // Fill the vector table and derive expected outputs from the model.
      vecs[0] = '{1'b1, 1'b1, 18'h3FFFF, 18'h0};
      vecs[1] = '{1'b1, 1'b0, 18'h00000, 18'h0};
      vecs[2] = '{1'b1, 1'b0, 18'h2AAAA, 18'h0};
      for (int i = 3; i < 8; i++)
         vecs[i] = '{(i == 6), 1'($urandom_range(0, 3) != 0), 18'($urandom), 18'h0};
      ms = '0;
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_reset) ms = '0;
         ms = model_duplex(ms, vecs[i].mav, vecs[i].din, 18, 176);
         vecs[i].exp = ms[17:0];
      end
      single_exp = vecs[0].exp;

      do_reset();
      for (int i = 0; i < 5; i++) begin
         check("reset_busy", 272'(busy), 272'(0));
         check("reset_dout", 272'(dout), 272'(0));
         check("reset_busy88", 272'(busy2), 272'(0));
         @(negedge clk);
      end

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_reset) do_reset();
         run_call(0, vecs[i].mav, vecs[i].din, -1, -1, nb);
         check($sformatf("vec%0d_busy_cycles", i), 272'(nb), 272'(90));
         check($sformatf("vec%0d_dout", i), 272'(dout), 272'(vecs[i].exp));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_stable", 272'(dout), 272'(vecs[7].exp));
      end

      // Starts during busy must be ignored.
      do_reset();
      run_call(0, 1'b1, 18'h3FFFF, 10, 40, nb);
      check("ignored_busy_cycles", 272'(nb), 272'(90));
      check("ignored_dout", 272'(dout), 272'(single_exp));

      // Back-to-back duplex calls, second issued in the first idle cycle.
      do_reset();
      ms = '0;
      run_call(0, 1'b1, 18'h12345, -1, -1, nb);
      t1 = $time;
      ms = model_duplex(ms, 1'b1, 18'h12345, 18, 176);
      check("b2b_first", 272'(dout), 272'(ms[17:0]));
      run_call(0, 1'b1, 18'h0ABCD, -1, -1, nb);
      t2 = $time;
      ms = model_duplex(ms, 1'b1, 18'h0ABCD, 18, 176);
      check("b2b_second", 272'(dout), 272'(ms[17:0]));
      check("b2b_period", 272'((t2 - t1) / 10), 272'(91));

      // Reset in the middle of a permutation.
      do_reset();
      start = 1'b1; msg = 1'b1; din = 18'h3FFFF;
      @(negedge clk);
      start = 1'b0; msg = 1'b0;
      nb = 0;
      while (busy && nb < 45) begin nb++; @(negedge clk); end
      check("midreset_reached", 272'(nb), 272'(45));
      reset = 1'b1;
      @(negedge clk);
      check("midreset_busy", 272'(busy), 272'(0));
      check("midreset_dout", 272'(dout), 272'(0));
      reset = 1'b0;
      run_call(0, 1'b1, 18'h3FFFF, -1, -1, nb);
      check("after_reset_dout", 272'(dout), 272'(single_exp));

      // b=88 instance, chained random calls.
      do_reset();
      ms = '0;
      for (int i = 0; i < 3; i++) begin
         din = 18'($urandom_range(0, 255));
         run_call(1, 1'b1, din, -1, -1, nb);
         ms = model_duplex(ms, 1'b1, din, 8, 88);
         check($sformatf("b88_call%0d_busy_cycles", i), 272'(nb), 272'(45));
         check($sformatf("b88_call%0d_dout", i), 272'(dout2), 272'(ms[7:0]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
